// File: rtl/pulse_gen_multi.sv
// pulse_gen_multi: per-channel one-shot/retriggerable/periodic pulse generator; shared cfg write port (cfg_we/cfg_ch/cfg_mode/cfg_period/cfg_width), per-channel trigger in, pulse_out and busy out
module pulse_gen_multi #(
  parameter int CHANNELS = 4,
  parameter int CNT_W = 8,
  localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic [CNT_W-1:0]    cfg_width,
  input  logic [CHANNELS-1:0] trigger,
  output logic [CHANNELS-1:0] pulse_out,
  output logic [CHANNELS-1:0] busy
);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [1:0] mode_q, mode_d;
    logic [CNT_W-1:0] period_q, period_d, width_q, width_d, cnt_q, cnt_d;
    logic busy_q, busy_d, pulse_q, pulse_d, wr, start;
    always_comb begin
      wr = cfg_we && cfg_ch == CH_W'(c);
      start = trigger[c] && (mode_q == 2'b10 ? period_q != '0 && !busy_q
                                             : mode_q != 2'b00 && width_q != '0 && (!busy_q || mode_q == 2'b11));
      mode_d = wr ? cfg_mode : mode_q;
      period_d = wr ? cfg_period : period_q;
      width_d = wr ? cfg_width : width_q;
      cnt_d = wr || start ? '0 : !busy_q ? cnt_q : mode_q == 2'b10 && cnt_q == period_q - 1'b1 ? '0 : cnt_q + 1'b1;
      busy_d = !wr && (start || (busy_q && (mode_q == 2'b10 || cnt_d < width_q)));
      pulse_d = busy_d && cnt_d < width_q;
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mode_q <= '0;
        period_q <= '0;
        width_q <= '0;
        cnt_q <= '0;
        busy_q <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        mode_q <= mode_d;
        period_q <= period_d;
        width_q <= width_d;
        cnt_q <= cnt_d;
        busy_q <= busy_d;
        pulse_q <= pulse_d;
      end
    end
    assign pulse_out[c] = pulse_q;
    assign busy[c] = busy_q;
  end
endmodule

// File: tb/tb_pulse_gen_multi.sv
// tb_pulse_gen_multi: directed self-checking bench for pulse_gen_multi
module tb_pulse_gen_multi;
  logic clk = 1'b0, rst = 1'b1, cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0, cfg_mode = '0;
  logic [7:0] cfg_period = '0, cfg_width = '0;
  logic [3:0] trigger = '0, pulse_out, busy;
  int checks = 0, errors = 0;

  pulse_gen_multi #(.CHANNELS(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_period(cfg_period), .cfg_width(cfg_width), .trigger(trigger),
    .pulse_out(pulse_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [1:0] mode, input logic [7:0] per, input logic [7:0] wid);
    cfg_ch = ch; cfg_mode = mode; cfg_period = per; cfg_width = wid; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    logic [6:0] rt_trig, rt_exp;
    logic [11:0] per_exp;
    tick(); tick();
    chk("reset_pulse", pulse_out, 4'b0000);
    chk("reset_busy", busy, 4'b0000);
    rst = 1'b0;
    trigger = 4'hF; tick(); trigger = '0;
    chk("off_pulse", pulse_out, 4'b0000);
    chk("off_busy", busy, 4'b0000);
    // async reset mid-run
    cfg(2'd0, 2'b10, 8'd5, 8'd2);
    trigger = 4'b0001; tick(); trigger = '0;
    chk("pre_rst_pulse", pulse_out, 4'b0001);
    chk("pre_rst_busy", busy, 4'b0001);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pulse", pulse_out, 4'b0000);
    chk("async_rst_busy", busy, 4'b0000);
    #1 rst = 1'b0;
    trigger = 4'b0001; tick(); trigger = '0;
    chk("post_rst_off", busy, 4'b0000);
    // one-shot width 3 with retrigger ignored
    cfg(2'd1, 2'b01, 8'd0, 8'd3);
    trigger = 4'b0010; tick();
    chk("os_e0_pulse", pulse_out, 4'b0010);
    chk("os_e0_busy", busy, 4'b0010);
    tick(); trigger = '0;
    chk("os_e1_pulse", pulse_out, 4'b0010);
    tick();
    chk("os_e2_pulse", pulse_out, 4'b0010);
    chk("os_e2_busy", busy, 4'b0010);
    tick();
    chk("os_e3_pulse", pulse_out, 4'b0000);
    chk("os_e3_busy", busy, 4'b0000);
    // retriggerable width 4, triggers two edges apart
    cfg(2'd2, 2'b11, 8'd0, 8'd4);
    rt_trig = 7'b0000101;
    rt_exp = 7'b0111111;
    for (int i = 0; i < 7; i++) begin
      trigger = {1'b0, rt_trig[i], 2'b00};
      tick();
      chk($sformatf("rt_e%0d_pulse", i), pulse_out, {1'b0, rt_exp[i], 2'b00});
      chk($sformatf("rt_e%0d_busy", i), busy, {1'b0, rt_exp[i], 2'b00});
    end
    trigger = '0;
    // periodic 5/2
    cfg(2'd0, 2'b10, 8'd5, 8'd2);
    per_exp = 12'b110001100011;
    trigger = 4'b0001;
    for (int i = 0; i < 12; i++) begin
      tick();
      trigger = '0;
      chk($sformatf("per_e%0d_pulse", i), pulse_out, {3'b000, per_exp[i]});
      chk($sformatf("per_e%0d_busy", i), busy, 4'b0001);
    end
    // cfg write aborts; simultaneous trigger on same channel is dropped
    trigger = 4'b0001;
    cfg(2'd0, 2'b10, 8'd5, 8'd2);
    trigger = '0;
    chk("abort_pulse", pulse_out, 4'b0000);
    chk("abort_busy", busy, 4'b0000);
    tick();
    chk("abort_nostart", busy, 4'b0000);
    // period 0 never starts
    cfg(2'd0, 2'b10, 8'd0, 8'd3);
    trigger = 4'b0001; tick(); trigger = '0;
    chk("per0_busy", busy, 4'b0000);
    // width >= period: constant high
    cfg(2'd0, 2'b10, 8'd5, 8'd7);
    trigger = 4'b0001;
    for (int i = 0; i < 7; i++) begin
      tick();
      trigger = '0;
      chk($sformatf("wide_e%0d_pulse", i), pulse_out, 4'b0001);
    end
    cfg(2'd0, 2'b00, 8'd0, 8'd0);
    chk("wide_off_busy", busy, 4'b0000);
    // width 0 one-shot never runs
    cfg(2'd1, 2'b01, 8'd0, 8'd0);
    trigger = 4'b0010; tick(); trigger = '0;
    chk("os_w0_busy", busy, 4'b0000);
    // independence: ch0 periodic 4/1 and ch3 one-shot 2
    cfg(2'd0, 2'b10, 8'd4, 8'd1);
    cfg(2'd3, 2'b01, 8'd0, 8'd2);
    trigger = 4'b1001; tick(); trigger = '0;
    chk("ind_e0_pulse", pulse_out, 4'b1001);
    chk("ind_e0_busy", busy, 4'b1001);
    tick();
    chk("ind_e1_pulse", pulse_out, 4'b1000);
    tick();
    chk("ind_e2_pulse", pulse_out, 4'b0000);
    chk("ind_e2_busy", busy, 4'b0001);
    cfg(2'd3, 2'b01, 8'd0, 8'd2);
    chk("ind_e3_pulse", pulse_out, 4'b0000);
    chk("ind_e3_busy", busy, 4'b0001);
    tick();
    chk("ind_e4_pulse", pulse_out, 4'b0001);
    tick();
    chk("ind_e5_pulse", pulse_out, 4'b0000);
    chk("ind_e5_busy", busy, 4'b0001);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pulse_gen_multi.md
Name: pulse_gen_multi

Overview:
Parametrised multi-channel pulse generator; successor to the single-output pulse generator test block. Each channel holds its own period, high-width and mode, all written through one shared config port. Each channel produces a registered pulse train or single pulse on its own output. Used as the on-chip stimulus/clock-divider source for timing and clocking experiments.

Parameters:
CHANNELS, 4, number of independent pulse channels (1..16)
CNT_W, 8, width of period/width counters; max period 2^CNT_W-1 cycles
CH_W, $clog2(CHANNELS) min 1, width of channel select (derived, not overridden)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
cfg_we  in  1  config write strobe, one write per cycle
cfg_ch  in  CH_W  channel addressed by cfg write
cfg_mode  in  2  00 off, 01 one-shot, 10 periodic, 11 retriggerable one-shot
cfg_period  in  CNT_W  period in cycles (periodic mode)
cfg_width  in  CNT_W  high time in cycles
trigger  in  CHANNELS  per-channel start request, level sampled each edge
pulse_out  out  CHANNELS  registered pulse outputs
busy  out  CHANNELS  channel running (registered)

Behaviour:
- rst asserted (async): all mode/period/width regs 0, counters 0, pulse_out 0, busy 0. Holds while rst high. Async assert, sync deassert assumed at system level.
- cfg write: on edge with cfg_we=1, channel cfg_ch loads mode/period/width. It also aborts that channel: counter 0, busy 0, pulse_out 0 after the same edge. cfg_ch >= CHANNELS: write ignored.
- Same edge, cfg write and trigger on same channel: config wins; trigger ignored. Other channels are unaffected.
- Per-channel counter cnt (CNT_W bits). Output rule while running: pulse_out = (cnt < width), computed from next-state cnt so the output is registered with zero extra lag.
- Mode 00 off: trigger ignored, outputs 0.
- Mode 01 one-shot:
  - Trigger=1 at edge k with busy=0 and width!=0: busy=1, cnt=0, pulse_out=1 after edge k.
  - cnt increments each edge. After edge k+width: pulse_out=0, busy=0.
  - Pulse is exactly width cycles. Trigger while busy is ignored.
  - width=0: trigger ignored, no pulse.
- Mode 11 retriggerable: as 01, but trigger=1 while busy reloads cnt=0. Pulse extends to width cycles after the last trigger edge.
- Mode 10 periodic:
  - Trigger at edge k with busy=0 and period!=0: start. cnt wraps period-1 -> 0.
  - pulse_out high for the first width cycles of each period, starting after edge k.
  - Runs until cfg write or rst. Trigger while running is ignored.
  - period=0: never starts.
  - width=0: busy=1 with output constantly 0.
  - width>=period: output constantly 1 while running.
- Counter arithmetic: wrap-free in one-shot modes (stops at width). Periodic wrap uses an explicit compare to period-1, never natural overflow.
- Channels are fully independent. Multiple simultaneous triggers start together, aligned.

Test Plan:
- Reset: rst=1 mid-run with channel 0 periodic -> pulse_out=0, busy=0 immediately (async, no clk edge). After release, trigger with no cfg -> nothing (mode 00).
- One-shot: ch1 mode=01 width=3, trigger pulse at edge 10 -> pulse_out[1] high exactly cycles 10..12, busy[1] same. Retrigger at edge 11 -> ignored, still 3 cycles.
- Retriggerable: ch2 mode=11 width=4, triggers at edges 20 and 22 -> pulse_out[2] high edges 20..25 (6 cycles), busy low after edge 26.
- Periodic: ch0 mode=10 period=5 width=2, trigger at edge 30 -> pattern 1,1,0,0,0 repeating. Output high at edges 30,31,35,36,40,41. Then cfg write to ch0 at edge 43 -> output 0, busy 0 after 43.
- Boundaries: period=0 periodic -> never busy; width=7 period=5 -> constant 1; width=0 one-shot -> no busy. cfg write and trigger on the same edge, same channel -> no start.
- Independence: ch0 periodic 4/1 and ch3 one-shot width 2 triggered on the same edge -> both rise together. A cfg write to ch3 does not disturb ch0's pattern.
